// File: rtl/fir_out_requant_if.sv
// Streaming bundle between the FIR result register, the requantizer and its consumer.
// The slave side is the requantizer: it takes filter results in and offers 16-bit samples out.
interface fir_out_requant_if;
    logic signed [32:0] sample_in;
    logic               sample_in_valid;
    logic signed [15:0] sample_out;
    logic               sample_out_valid;
    logic               sample_out_ready;

    modport slave (
        input  sample_in, sample_in_valid, sample_out_ready,
        output sample_out, sample_out_valid
    );

    modport master (
        output sample_in, sample_in_valid, sample_out_ready,
        input  sample_out, sample_out_valid
    );
endinterface

// File: rtl/fir_out_requant.sv
// Decimates the 33-bit FIR result stream, rounds half-up and saturates to 16 bits,
// and queues kept samples in a small FIFO with a registered valid/ready output.
module fir_out_requant #(
    parameter int DECIM      = 2,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_enable,
    fir_out_requant_if.slave              bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sat_flag,
    output logic                          ovf_flag
);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DECIM - 1);
    localparam logic [PW:0]   LVL_FULL = (PW+1)'(FIFO_DEPTH);

    logic [CW-1:0]      dec_cnt;
    logic               accept, keep;
    logic signed [33:0] ext, rnd, shr;
    logic signed [15:0] sat_val;
    logic               clamp;

    logic               stage_valid;
    logic signed [15:0] stage_data;

    logic signed [15:0] mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr, rd_nxt;
    logic [PW:0]        lvl_nxt;
    logic               pop, push_try, push, full;
    logic signed [15:0] head_nxt;

    assign accept = clk_enable & bus.sample_in_valid;
    assign keep   = accept & (dec_cnt == '0);

    // 34 bits leave headroom for the rounding add on the most positive input.
    always_comb begin
        ext     = {bus.sample_in[32], bus.sample_in};
        rnd     = ext + (34'sd1 <<< (SHIFT - 1));
        shr     = rnd >>> SHIFT;
        sat_val = shr[15:0];
        clamp   = 1'b0;
        if (shr > 34'sd32767) begin
            sat_val = 16'sh7fff;
            clamp   = 1'b1;
        end else if (shr < -34'sd32768) begin
            sat_val = -16'sh8000;
            clamp   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt     <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            sat_flag    <= 1'b0;
        end else if (clk_enable) begin
            stage_valid <= keep;
            if (accept)
                dec_cnt <= (dec_cnt == CNT_MAX) ? '0 : dec_cnt + CW'(1);
            if (keep)
                stage_data <= sat_val;
            if (keep && clamp)
                sat_flag <= 1'b1;
        end
    end

    assign full     = (fifo_level == LVL_FULL);
    assign pop      = clk_enable & bus.sample_out_valid & bus.sample_out_ready;
    assign push_try = clk_enable & stage_valid;
    assign push     = push_try & (~full | pop);
    assign rd_nxt   = rd_ptr + PW'(pop);
    assign lvl_nxt  = fifo_level + (PW+1)'(push) - (PW+1)'(pop);

    // The output register is loaded with whatever will be at the head after this edge;
    // that is the incoming stage value when it lands in the slot being read next.
    assign head_nxt = (push && (wr_ptr == rd_nxt)) ? stage_data : mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= stage_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            fifo_level           <= '0;
            bus.sample_out       <= '0;
            bus.sample_out_valid <= 1'b0;
            ovf_flag             <= 1'b0;
        end else if (clk_enable) begin
            wr_ptr               <= wr_ptr + PW'(push);
            rd_ptr               <= rd_nxt;
            fifo_level           <= lvl_nxt;
            bus.sample_out_valid <= (lvl_nxt != '0);
            if (lvl_nxt != '0)
                bus.sample_out <= head_nxt;
            if (push_try && !push)
                ovf_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fir_out_requant.sv
// Drives three requantizers (DECIM 1, 2, 3) with one shared stream and compares every
// output each cycle against a queue-based model of decimate/round/saturate/FIFO behaviour.
module tb_fir_out_requant;
    localparam int NI    = 3;
    localparam int SHIFT = 15;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_enable;
    logic               vin;
    logic               ready;
    logic signed [32:0] din;

    logic signed [15:0] so   [NI];
    logic               sov  [NI];
    logic [2:0]         lvl  [NI];
    logic               satf [NI];
    logic               ovff [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fir_out_requant_if bus ();
        assign bus.sample_in        = din;
        assign bus.sample_in_valid  = vin;
        assign bus.sample_out_ready = ready;
        assign so[g]  = bus.sample_out;
        assign sov[g] = bus.sample_out_valid;
        fir_out_requant #(.DECIM(g + 1), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) dut (
            .clk        (clk),
            .reset      (reset),
            .clk_enable (clk_enable),
            .bus        (bus),
            .fifo_level (lvl[g]),
            .sat_flag   (satf[g]),
            .ovf_flag   (ovff[g])
        );
    end

    int errs   = 0;
    int checks = 0;

    int m_cnt [NI];
    bit m_sv  [NI];
    int m_sd  [NI];
    int mq    [NI][$];
    int m_out [NI];
    bit m_sat [NI];
    bit m_ovf [NI];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Round half toward +inf after scaling by 2^-SHIFT, using floor division.
    function automatic longint round_shift(input longint x);
        longint y, d, q;
        d = longint'(1) << SHIFT;
        y = x + (d / 2);
        q = y / d;
        if ((y % d != 0) && (y < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0;
            m_sv[i]  = 0;
            m_sd[i]  = 0;
            mq[i].delete();
            m_out[i] = 0;
            m_sat[i] = 0;
            m_ovf[i] = 0;
        end
    endtask

    task automatic model_edge(input bit en, input bit v, input longint x, input bit rdy);
        longint q;
        if (!en) return;
        for (int i = 0; i < NI; i++) begin
            if (rdy && mq[i].size() > 0) void'(mq[i].pop_front());
            if (m_sv[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(m_sd[i]);
                else m_ovf[i] = 1;
            end
            if (mq[i].size() > 0) m_out[i] = mq[i][0];
            m_sv[i] = 0;
            if (v) begin
                if (m_cnt[i] == 0) begin
                    q = round_shift(x);
                    if (q > 32767)       begin q = 32767;  m_sat[i] = 1; end
                    else if (q < -32768) begin q = -32768; m_sat[i] = 1; end
                    m_sd[i] = int'(q);
                    m_sv[i] = 1;
                end
                m_cnt[i] = (m_cnt[i] + 1) % (i + 1);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("d%0d.valid", i + 1), sov[i],  (mq[i].size() > 0) ? 64'sd1 : 64'sd0);
            chk($sformatf("d%0d.level", i + 1), lvl[i],  mq[i].size());
            chk($sformatf("d%0d.out",   i + 1), so[i],   m_out[i]);
            chk($sformatf("d%0d.sat",   i + 1), satf[i], m_sat[i]);
            chk($sformatf("d%0d.ovf",   i + 1), ovff[i], m_ovf[i]);
        end
    endtask

    task automatic step(input bit en, input bit v, input longint x, input bit rdy);
        clk_enable = en;
        vin        = v;
        din        = x[32:0];
        ready      = rdy;
        @(posedge clk);
        model_edge(en, v, longint'($signed(x[32:0])), rdy);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 0, rdy);
    endtask

    // Reset takes effect immediately, is held across one edge, then released mid-cycle.
    task automatic do_reset();
        reset = 1'b1;
        vin   = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    function automatic longint rand_sample();
        logic signed [32:0] t;
        longint x;
        case ($urandom_range(0, 3))
            0: begin t = 33'({$urandom(), $urandom()}); x = t; end
            1: x = longint'($urandom_range(0, 2097152)) - 1048576;
            2: x = (longint'(32767) << 15) + longint'($urandom_range(0, 65536)) - 32768;
            default: x = (-(longint'(32768) << 15)) + longint'($urandom_range(0, 65536)) - 32768;
        endcase
        return x;
    endfunction

    initial begin
        longint rvals [5];
        reset      = 1'b1;
        clk_enable = 1'b0;
        vin        = 1'b0;
        ready      = 1'b0;
        din        = '0;
        #3;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // rounding boundaries
        rvals = '{32768, 16384, -16384, -16385, 49151};
        foreach (rvals[k]) step(1'b1, 1'b1, rvals[k], 1'b1);
        idle(3, 1'b1);

        // saturation both ways
        step(1'b1, 1'b1, (longint'(1) << 32) - 1, 1'b1);
        step(1'b1, 1'b1, -(longint'(1) << 32), 1'b1);
        idle(3, 1'b1);

        // decimation from an aligned counter
        do_reset();
        for (int k = 1; k <= 6; k++) step(1'b1, 1'b1, 32768 * k, 1'b1);
        idle(4, 1'b1);

        // fill past full with no consumer, then drain
        do_reset();
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b1, 32768 * k, 1'b0);
        idle(2, 1'b0);
        idle(6, 1'b1);

        // sustained push and pop at full level
        do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, 32768 * k, 1'b0);
        idle(1, 1'b0);
        for (int k = 5; k <= 14; k++) step(1'b1, 1'b1, 32768 * k, 1'b1);
        idle(6, 1'b1);

        // clock enable freeze, then reset with entries queued
        step(1'b1, 1'b1, 32768 * 20, 1'b0);
        step(1'b1, 1'b1, 32768 * 21, 1'b0);
        idle(2, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32768 * 22, 1'b1);
        do_reset();
        step(1'b1, 1'b1, 32768 * 7, 1'b1);
        idle(3, 1'b1);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, rand_sample(),
                 $urandom_range(0, 2) != 0);
        end
        idle(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fir_out_requant.md
# fir_out_requant

Output-side companion to the direct-form FIR filter: consumes the filter's 33-bit full-precision result stream and converts it back to 16-bit samples for downstream logic. It decimates by a fixed factor, rounds and saturates each kept sample, and buffers the results in a small FIFO with a valid/ready output handshake. It sits directly behind the FIR's `filter_out` register and shares its clock and clock enable.

## Interface

Parameters:
- `DECIM`, default 2: decimation factor, 1..16. A value of 1 keeps every sample.
- `SHIFT`, default 15: arithmetic right shift applied before rounding, 1..17. It matches the Q15 coefficient scaling.
- `FIFO_DEPTH`, default 4: output FIFO entries. Must be a power of 2, at least 2.

Ports:
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high. Clears all state.
- `clk_enable`, in, 1: when low, all state is frozen, including the handshake.
- `sample_in`, in, 33: signed FIR result.
- `sample_in_valid`, in, 1: `sample_in` is present this cycle. No backpressure toward the filter.
- `sample_out`, out, 16: signed requantized sample at the FIFO head.
- `sample_out_valid`, out, 1: the FIFO is non-empty.
- `sample_out_ready`, in, 1: the downstream consumer accepts `sample_out`.
- `fifo_level`, out, clog2(FIFO_DEPTH)+1: number of occupied entries.
- `sat_flag`, out, 1: sticky. Set when any kept sample saturated.
- `ovf_flag`, out, 1: sticky. Set when a kept sample was dropped because the FIFO was full.

## Operation

- **Active cycle definition.** An active cycle is a rising edge with `clk_enable`=1. Nothing changes on other edges.
- **Accept.** An input is accepted on an active cycle with `sample_in_valid`=1.
- **Decimation counter.**
  - Range 0..DECIM-1, reset value 0.
  - It increments on each accepted input and wraps from DECIM-1 to 0.
  - An input is kept when the counter equals 0 at acceptance. All other inputs are discarded.
- **Arithmetic, for kept samples, in 34 bits.**
  - Sign-extend `sample_in` to 34 bits.
  - Add 2^(SHIFT-1), which gives round-half-up (toward +inf).
  - Arithmetic-shift right by SHIFT.
  - Saturate to [-32768, 32767]. If clamping occurred, set `sat_flag`.
  - The 34-bit width guarantees no internal wrap.
- **Stage register.**
  - The rounded/saturated value and a `stage_valid` bit are registered on the accept edge.
  - `stage_valid` reset value is 0.
- **FIFO write.**
  - On the next active cycle, if `stage_valid`=1, the value is written to the FIFO.
  - The write succeeds if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the value is dropped, `ovf_flag` is set, and the FIFO contents are unchanged.
- **FIFO pop.** A pop happens on an active cycle with `sample_out_valid`=1 and `sample_out_ready`=1.
- **Simultaneous push and pop.**
  - Allowed at any level, including full.
  - The level is unchanged.
  - Order is preserved, so `sample_out` shows the next-oldest entry.
- **Empty FIFO.** `sample_out_valid`=0. `sample_out` holds its last value and is don't-care to the consumer. There is no fall-through bypass.
- **Pointer wrap.** Read and write pointers wrap modulo FIFO_DEPTH. Full is `fifo_level`=FIFO_DEPTH.
- **Sticky flags.** `sat_flag` and `ovf_flag` are cleared only by `reset`.

## Timing

- **Reset values** (asynchronous, immediate on `reset`=1):
  - `sample_out`=0, `sample_out_valid`=0, `fifo_level`=0, `sat_flag`=0, `ovf_flag`=0.
  - Decimation counter = 0, `stage_valid`=0, FIFO pointers = 0.
- **Latency.** A kept sample accepted at active edge k is written at active edge k+1. With an empty FIFO, `sample_out_valid` is high after edge k+1, a 2-edge latency.
- **Throughput.** One input per active cycle. At most one FIFO write per active cycle.
- **`sat_flag` timing.** Set at the accept edge of the saturating sample.
- **`ovf_flag` timing.** Set at the failed write edge.
- **`clk_enable` low.**
  - Outputs hold their values.
  - A pop does not occur even if `sample_out_ready`=1.
  - `sample_in_valid` is ignored.
- **Reset mid-operation.** Any in-flight stage sample and all FIFO contents are lost. The first input accepted after reset release is kept, because the counter is 0.
- **`sample_out` stability.** `sample_out` and `sample_out_valid` are registered and change only on active edges or reset.

## Test plan

- **Rounding** (DECIM=1, SHIFT=15). Inputs 32768, 16384, -16384, -16385, 49151 → outputs 1, 1, 0, -1, 1. `sat_flag` stays 0. Each `sample_out_valid` asserts 2 edges after its input.
- **Saturation.** Input 2^32-1 → 32767 with `sat_flag`=1. Input -2^32 → -32768. `sat_flag` stays 1 until `reset`.
- **Decimation** (DECIM=2). Inputs 32768×{1,2,3,4,5} on consecutive cycles → outputs 1, 3, 5 in order. With DECIM=3 and inputs ×{1..6} → outputs 1, 4.
- **FIFO full and overflow** (DEPTH=4, DECIM=1). Hold `sample_out_ready`=0 and send 5 samples → `fifo_level`=4, `ovf_flag`=1. Then raise ready → samples 1..4 drain in order and sample 5 never appears.
- **Simultaneous push/pop at full.** Keep the FIFO at level 4 with ready=1 and a continuous input stream → level stays 4, no overflow, outputs emerge in order.
- **Reset and `clk_enable`.**
  - Drop `clk_enable` for 3 cycles while ready=1 → no pops, level unchanged.
  - Then assert `reset` with 2 entries queued → `sample_out_valid`=0 and level=0 immediately.
  - After release, the first input is kept.
